// File: rtl/gb_host_bridge.sv
// Host-side ghostbus master: one read/write request in, one ghostbus strobe out,
// one response back. A single transaction is in flight at a time.
module gb_host_bridge #(
   parameter int unsigned AW         = 24,
   parameter int unsigned DW         = 32,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic          i_req_we,
   input  logic [AW-1:0] i_req_addr,
   input  logic [DW-1:0] i_req_wdata,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic          o_rsp_we,
   output logic [DW-1:0] o_rsp_rdata,
   output logic [AW-1:0] o_gb_addr,
   output logic [DW-1:0] o_gb_dout,
   output logic          o_gb_we,
   output logic          o_gb_re,
   input  logic [DW-1:0] i_gb_din
);

   localparam logic [3:0] LatLoad = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StStrobe, StWait, StResp} state_t;

   state_t          r_state, w_state_d;
   logic            r_we;
   logic [3:0]      r_cnt, w_cnt_d;
   logic            r_rsp_we, w_rsp_we_d;
   logic [DW-1:0]   r_rdata, w_rdata_d;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_dout;
   logic            w_accept;

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_rsp_we_d  = r_rsp_we;
      w_rdata_d   = r_rdata;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_gb_we     = 1'b0;
      o_gb_re     = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_state_d = StStrobe;
         end
         StStrobe: begin
            o_gb_we = r_we;
            o_gb_re = ~r_we;
            if (r_we) begin
               w_rsp_we_d = 1'b1;
               w_rdata_d  = '0;
               w_state_d  = StResp;
            end else if (RD_LATENCY == 0) begin
               w_rsp_we_d = 1'b0;
               w_rdata_d  = i_gb_din;
               w_state_d  = StResp;
            end else begin
               w_rsp_we_d = 1'b0;
               w_cnt_d    = LatLoad;
               w_state_d  = StWait;
            end
         end
         StWait: begin
            // Counter reaching zero marks the cycle in which gb_din is valid.
            if (r_cnt == 4'd0) begin
               w_rdata_d = i_gb_din;
               w_state_d = StResp;
            end else begin
               w_cnt_d = r_cnt - 4'd1;
            end
         end
         StResp: begin
            o_rsp_valid = 1'b1;
            o_req_ready = i_rsp_ready;
            if (i_rsp_ready) w_state_d = i_req_valid ? StStrobe : StIdle;
         end
         default: w_state_d = StIdle;
      endcase
      if (i_rst) o_req_ready = 1'b0;
   end

   assign w_accept = o_req_ready & i_req_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_cnt    <= 4'd0;
         r_rsp_we <= 1'b0;
         r_rdata  <= '0;
         r_addr   <= '0;
         r_dout   <= '0;
         r_we     <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_cnt    <= w_cnt_d;
         r_rsp_we <= w_rsp_we_d;
         r_rdata  <= w_rdata_d;
         // Bus address/data only move on acceptance and hold otherwise.
         if (w_accept) begin
            r_addr <= i_req_addr;
            r_dout <= i_req_wdata;
            r_we   <= i_req_we;
         end
      end
   end

   assign o_rsp_we    = r_rsp_we;
   assign o_rsp_rdata = r_rdata;
   assign o_gb_addr   = r_addr;
   assign o_gb_dout   = r_dout;

endmodule

// File: tb/tb_gb_host_bridge.sv
// Bench for gb_host_bridge: four instances (RD_LATENCY 2,0,1,7) under random requests,
// back-pressure and reset pulses, checked cycle by cycle against a queue-based model.
module tb_gb_host_bridge;

   localparam int NTX = 120;

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [31:0] wdata;
      int          scyc;
   } strb_t;

   typedef struct {
      logic        we;
      logic [31:0] rdata;
      int          rcyc;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Ghostbus read data is a distinct value every cycle so the sampling cycle is observable.
   function automatic logic [31:0] din_of(input int c, input int k);
      return (32'(c) * 32'h9E37_79B1) ^ (32'(k) << 28) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input int k, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc=%0d got=%h exp=%h", name, k, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_inst
      localparam int L = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 1 : 7;

      logic        rst, req_valid, req_ready, req_we;
      logic        rsp_valid, rsp_ready, rsp_we, gb_we, gb_re;
      logic [23:0] req_addr, gb_addr;
      logic [31:0] req_wdata, rsp_rdata, gb_dout, gb_din;
      logic        done = 1'b0;

      strb_t       sq[$];
      rsp_t        rq[$];
      logic [23:0] m_addr = '0;
      logic [31:0] m_dout = '0;
      logic        m_prev_rst = 1'b0;

      assign gb_din = din_of(cyc, g);

      gb_host_bridge #(
         .AW         (24),
         .DW         (32),
         .RD_LATENCY (L)
      ) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_req_valid (req_valid),
         .o_req_ready (req_ready),
         .i_req_we    (req_we),
         .i_req_addr  (req_addr),
         .i_req_wdata (req_wdata),
         .o_rsp_valid (rsp_valid),
         .i_rsp_ready (rsp_ready),
         .o_rsp_we    (rsp_we),
         .o_rsp_rdata (rsp_rdata),
         .o_gb_addr   (gb_addr),
         .o_gb_dout   (gb_dout),
         .o_gb_we     (gb_we),
         .o_gb_re     (gb_re),
         .i_gb_din    (gb_din)
      );

      initial begin : rsp_drv
         int burst;
         burst     = 0;
         rsp_ready = 1'b1;
         forever begin
            @(posedge clk); #1;
            if (burst > 0) begin
               rsp_ready = 1'b0;
               burst--;
            end else if ($urandom_range(0, 11) == 0) begin
               rsp_ready = 1'b0;
               burst     = int'($urandom_range(0, 5));
            end else begin
               rsp_ready = 1'b1;
            end
         end
      end

      initial begin : rst_drv
         rst = 1'b1;
         repeat (3) begin @(posedge clk); #1; end
         rst = 1'b0;
         while (!done) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 79) == 0);
         end
         rst = 1'b0;
      end

      initial begin : req_drv
         logic got;
         req_valid = 1'b0;
         req_we    = 1'b0;
         req_addr  = '0;
         req_wdata = '0;
         repeat (5) begin @(posedge clk); #1; end
         for (int t = 0; t < NTX; t++) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 24'($urandom);
            req_wdata = $urandom;
            if (g == 0 && t == 0) begin
               req_we    = 1'b1;
               req_addr  = 24'h000010;
               req_wdata = 32'hDEAD_BEEF;
            end
            if (g == 0 && t == 1) begin
               req_we   = 1'b0;
               req_addr = 24'h000020;
            end
            got = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
               @(negedge clk);
               got = req_ready && !rst;
               @(posedge clk); #1;
            end
            chk("accepted", g, 64'(got), 64'd1);
            if ($urandom_range(0, 3) == 0) begin
               req_valid = 1'b0;
               repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            end
         end
         req_valid = 1'b0;
         repeat (60) begin @(posedge clk); #1; end
         chk("drain_rsp", g, 64'(rq.size()), 64'd0);
         chk("drain_strobe", g, 64'(sq.size()), 64'd0);
         done = 1'b1;
      end

      always @(negedge clk) begin : mon
         logic e_we, e_re, e_v, e_rdy;
         if (cyc >= 1) begin
            e_we = sq.size() > 0 && sq[0].scyc == cyc && sq[0].we;
            e_re = sq.size() > 0 && sq[0].scyc == cyc && !sq[0].we;
            chk("gb_we", g, 64'(gb_we), 64'(e_we));
            chk("gb_re", g, 64'(gb_re), 64'(e_re));
            chk("gb_addr", g, 64'(gb_addr), 64'(m_addr));
            chk("gb_dout", g, 64'(gb_dout), 64'(m_dout));
            if (sq.size() > 0 && sq[0].scyc == cyc) void'(sq.pop_front());

            e_v = rq.size() > 0 && cyc >= rq[0].rcyc;
            chk("rsp_valid", g, 64'(rsp_valid), 64'(e_v));
            if (e_v) begin
               chk("rsp_we", g, 64'(rsp_we), 64'(rq[0].we));
               chk("rsp_rdata", g, 64'(rsp_rdata), 64'(rq[0].rdata));
            end
            if (m_prev_rst && !e_v) begin
               chk("reset_rsp_we", g, 64'(rsp_we), 64'd0);
               chk("reset_rsp_rdata", g, 64'(rsp_rdata), 64'd0);
            end

            e_rdy = !rst && (rq.size() == 0 || (e_v && rsp_ready));
            chk("req_ready", g, 64'(req_ready), 64'(e_rdy));

            if (e_v && rsp_ready) void'(rq.pop_front());
            if (e_rdy && req_valid) begin
               sq.push_back('{we: req_we, addr: req_addr, wdata: req_wdata, scyc: cyc + 1});
               rq.push_back('{we: req_we,
                              rdata: req_we ? 32'd0 : din_of(cyc + 1 + L, g),
                              rcyc: cyc + 2 + (req_we ? 0 : L)});
               m_addr = req_addr;
               m_dout = req_wdata;
            end
            if (rst) begin
               sq.delete();
               rq.delete();
               m_addr = '0;
               m_dout = '0;
            end
            m_prev_rst = rst;
         end
      end
   end

   initial begin
      wait (g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done);
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench did not finish in time");
   end

endmodule
